// File: rtl/sc_arb_pkg.sv
// Shared definitions for the shared-counter arbiter: FSM encoding,
// counter geometry and the watchdog limit.
package sc_arb_pkg;

    localparam int CTR_W    = 3;
    localparam int CTR_MAX  = 7;
    localparam int WDOG_LIM = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A requested delay of zero still needs one counter tick to be observable.
    function automatic logic [CTR_W-1:0] eff_delay(input logic [CTR_W-1:0] d);
        return (d == '0) ? CTR_W'(1) : d;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright; on a tie the
// requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant from the request pair and the last-served pointer.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sc_arb.sv
// Grants one of two requesters the shared 3-bit counter, runs it for the
// latched delay, pulses done, and flags counter misbehaviour in a sticky err.
// All outputs decode registered state only, so req/ctr_out never reach them
// combinationally.
module sc_arb
    import sc_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [CTR_W-1:0] dly0,
    input  logic [CTR_W-1:0] dly1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             ctr_rst,
    input  logic [CTR_W-1:0] ctr_out,
    input  logic             ctr_err,
    output logic             err,
    output logic [1:0]       dbg_state_o
);

    localparam logic [CTR_W-1:0] WD_LAST = CTR_W'(WDOG_LIM - 1);

    state_e           state_q, state_d;
    logic             id_q, id_d;
    logic [CTR_W-1:0] eff_q, eff_d;
    logic             ptr_q, ptr_d;
    logic [CTR_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic [1:0]       arb_gnt;
    logic             run_err;
    logic             wdog_trip;

    rr_arb2 u_rr (
        .req_i  ({req1, req0}),
        .last_i (ptr_q),
        .gnt_o  (arb_gnt)
    );

    // State, latches, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            eff_q   <= '0;
            ptr_q   <= 1'b1;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            eff_q   <= eff_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitrate in IDLE, count RUN cycles until the counter
    // reaches the latched delay or the watchdog expires, then one DONE cycle.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        eff_d     = eff_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        run_err   = 1'b0;
        wdog_trip = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d = ST_RUN;
                    id_d    = arb_gnt[1];
                    eff_d   = eff_delay(arb_gnt[1] ? dly1 : dly0);
                    wd_d    = '0;
                end
            end
            ST_RUN: begin
                // Counter must start at zero and never overshoot the target.
                run_err = ((wd_q == '0) && (ctr_out != '0)) || (ctr_out > eff_q);
                if (ctr_out == eff_q) begin
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d   = ST_DONE;
                    wdog_trip = 1'b1;
                end else begin
                    wd_d = wd_q + CTR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = id_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = err_q | ctr_err | run_err | wdog_trip;
    end

    // Output decode from registered state and latched requester id.
    always_comb begin
        gnt0        = (state_q == ST_RUN)  && !id_q;
        gnt1        = (state_q == ST_RUN)  &&  id_q;
        done0       = (state_q == ST_DONE) && !id_q;
        done1       = (state_q == ST_DONE) &&  id_q;
        busy        = (state_q != ST_IDLE);
        ctr_rst     = (state_q != ST_RUN);
        err         = err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_sc_arb.sv
// Directed bench for sc_arb with a behavioural shared saturating counter.
module tb_sc_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] dly0 = 3'd0, dly1 = 3'd0;
    logic       gnt0, gnt1, done0, done1, busy, ctr_rst, err;
    logic [2:0] ctr_out = 3'd0;
    logic       ctr_err = 1'b0;
    logic [1:0] dbg_state;
    logic       stuck = 1'b0;
    logic [5:0] vec;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [5:0] V_IDLE = 6'b000001;
    localparam logic [5:0] V_RUN0 = 6'b010010;
    localparam logic [5:0] V_RUN1 = 6'b100010;
    localparam logic [5:0] V_DON0 = 6'b000111;
    localparam logic [5:0] V_DON1 = 6'b001011;

    sc_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .dly0        (dly0),
        .dly1        (dly1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .busy        (busy),
        .ctr_rst     (ctr_rst),
        .ctr_out     (ctr_out),
        .ctr_err     (ctr_err),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    assign vec = {gnt1, gnt0, done1, done0, busy, ctr_rst};

    always #5 clk = ~clk;

    // Shared counter: clears while ctr_rst is high, else counts up and saturates.
    always @(posedge clk) begin
        if (ctr_rst || stuck) ctr_out <= 3'd0;
        else if (ctr_out != 3'd7) ctr_out <= ctr_out + 3'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hold reset over two edges, check reset outputs, release at a negedge.
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vec", 8'(vec), 8'(V_IDLE));
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'd0);
        rst = 1'b1;
    endtask

    // Called at a negedge in IDLE with the request already driven; checks the
    // whole grant/count/done sequence and scribbles dly during RUN.
    task automatic txn(input logic id, input int eff);
        logic [2:0] s0, s1;
        logic [5:0] run_v, done_v;
        run_v  = id ? V_RUN1 : V_RUN0;
        done_v = id ? V_DON1 : V_DON0;
        chk("idle_vec", 8'(vec), 8'(V_IDLE));
        s0 = dly0;
        s1 = dly1;
        for (int k = 0; k <= eff; k++) begin
            @(negedge clk);
            chk("run_vec", 8'(vec), 8'(run_v));
            chk("run_ctr", 8'(ctr_out), 8'(k));
            if (k == 0) begin
                dly0 = ~s0;
                dly1 = ~s1;
            end
        end
        @(negedge clk);
        chk("done_vec", 8'(vec), 8'(done_v));
        dly0 = s0;
        dly1 = s1;
    endtask

    initial begin
        // Single requester, dly 3.
        req0 = 1'b1; dly0 = 3'd3;
        do_reset();
        txn(1'b0, 3);
        chk("t32_err", 8'(err), 8'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("t32_idle", 8'(vec), 8'(V_IDLE));

        // Tie from reset: req0, then req1, then req0 again.
        req0 = 1'b1; req1 = 1'b1; dly0 = 3'd2; dly1 = 3'd5;
        do_reset();
        txn(1'b0, 2);
        @(negedge clk);
        txn(1'b1, 5);
        @(negedge clk);
        txn(1'b0, 2);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("t33_idle", 8'(vec), 8'(V_IDLE));
        chk("t33_err", 8'(err), 8'd0);

        // Zero delay behaves as one.
        req1 = 1'b1; dly1 = 3'd0;
        txn(1'b1, 1);
        req1 = 1'b0;
        @(negedge clk);
        chk("t34_err", 8'(err), 8'd0);

        // Stuck counter trips the watchdog after 8 RUN cycles.
        stuck = 1'b1; req0 = 1'b1; dly0 = 3'd4;
        chk("t35_idle", 8'(vec), 8'(V_IDLE));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t35_run", 8'(vec), 8'(V_RUN0));
            chk("t35_err_run", 8'(err), 8'd0);
        end
        @(negedge clk);
        chk("t35_done", 8'(vec), 8'(V_DON0));
        chk("t35_err", 8'(err), 8'd1);
        req0 = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("t35_idle2", 8'(vec), 8'(V_IDLE));
        chk("t35_sticky", 8'(err), 8'd1);
        do_reset();
        @(negedge clk);

        // Reset in the second RUN cycle aborts; re-grant after release.
        req0 = 1'b1; dly0 = 3'd6;
        chk("t36_idle", 8'(vec), 8'(V_IDLE));
        @(negedge clk);
        chk("t36_run1", 8'(vec), 8'(V_RUN0));
        @(negedge clk);
        chk("t36_run2", 8'(vec), 8'(V_RUN0));
        rst = 1'b0;
        #1;
        chk("t36_async", 8'(vec), 8'(V_IDLE));
        chk("t36_state", 8'(dbg_state), 8'd0);
        @(negedge clk);
        chk("t36_nodone", 8'(vec), 8'(V_IDLE));
        rst = 1'b1;
        txn(1'b0, 6);
        req0 = 1'b0;
        @(negedge clk);

        // ctr_err pulse in IDLE sets err; arbitration still works.
        chk("t37_err0", 8'(err), 8'd0);
        ctr_err = 1'b1;
        @(negedge clk);
        ctr_err = 1'b0;
        chk("t37_err1", 8'(err), 8'd1);
        req1 = 1'b1; dly1 = 3'd2;
        txn(1'b1, 2);
        req1 = 1'b0;
        @(negedge clk);
        chk("t37_sticky", 8'(err), 8'd1);
        chk("t37_idle", 8'(vec), 8'(V_IDLE));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
